// File: rtl/issue_queue_ctrl_pkg.sv
// Shared opcode constants, RoB id width and the head-instruction classifier
// for the issue controller.
package issue_queue_ctrl_pkg;

   localparam int ROB_SIZE_WIDTH = 4;

   localparam logic [6:0] LUI     = 7'b0110111;
   localparam logic [6:0] AUIPC   = 7'b0010111;
   localparam logic [6:0] JAL     = 7'b1101111;
   localparam logic [6:0] JALR    = 7'b1100111;
   localparam logic [6:0] B_TYPE  = 7'b1100011;
   localparam logic [6:0] LD_TYPE = 7'b0000011;
   localparam logic [6:0] S_TYPE  = 7'b0100011;
   localparam logic [6:0] I_TYPE  = 7'b0010011;
   localparam logic [6:0] R_TYPE  = 7'b0110011;

   typedef enum logic [1:0] {
      TGT_RS,
      TGT_LSB,
      TGT_ILLEGAL
   } target_e;

   function automatic target_e classify(input logic [6:0] opcode);
      target_e t;
      case (opcode)
         LD_TYPE, S_TYPE: t = TGT_LSB;
         LUI, AUIPC, JAL, JALR, B_TYPE, I_TYPE, R_TYPE: t = TGT_RS;
         default: t = TGT_ILLEGAL;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/issue_queue_ctrl_fifo.sv
// Generic synchronous FIFO with clear; head entry is always presented on rdata.
// Callers guarantee no push when full and no pop when empty.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   assign rdata = mem[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= wdata;
            tail      <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/issue_queue_ctrl.sv
// In-order issue queue between Fetcher and Decoder: gates head issue on RoB and
// RS/LSB space, drops illegal opcodes, flushes on misprediction, counts stalls.
module issue_queue_ctrl
   import issue_queue_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ROB_W = ROB_SIZE_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_instr,
   input  logic [31:0]      fetch_addr,
   output logic             fetch_ready,
   input  logic             flush,
   input  logic             rob_full,
   input  logic [ROB_W-1:0] rob_tail_id,
   input  logic             rs_full,
   input  logic             lsb_full,
   output logic [31:0]      dec_instr,
   output logic [31:0]      dec_addr,
   output logic             issue_valid,
   output logic             issue_to_rs,
   output logic             issue_to_lsb,
   output logic [ROB_W-1:0] issue_rob_id,
   output logic             rob_alloc,
   output logic [31:0]      stall_cycles
);
   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];

   logic [AW:0]   count;
   logic [63:0]   head_word;
   logic          not_empty;
   logic          active;
   logic          target_free;
   logic          can_issue;
   logic          drop_illegal;
   logic          push;
   logic          pop;
   target_e       target;

   instr_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (rdy & flush),
      .push  (push),
      .pop   (pop),
      .wdata ({fetch_instr, fetch_addr}),
      .rdata (head_word),
      .count (count)
   );

   assign not_empty = (count != '0);
   assign active    = rdy & ~flush;

   // Empty queue shows zeros so the Decoder never sees a stale opcode.
   assign dec_instr = not_empty ? head_word[63:32] : '0;
   assign dec_addr  = not_empty ? head_word[31:0]  : '0;

   assign target      = classify(dec_instr[6:0]);
   assign target_free = (target == TGT_LSB) ? ~lsb_full : ~rs_full;

   assign can_issue    = active & not_empty & ~rob_full & target_free & (target != TGT_ILLEGAL);
   assign drop_illegal = active & not_empty & (target == TGT_ILLEGAL);

   assign fetch_ready = active & (count < DEPTH_CNT);
   assign push        = fetch_valid & fetch_ready;
   assign pop         = can_issue | drop_illegal;

   assign issue_valid  = can_issue;
   assign rob_alloc    = can_issue;
   assign issue_to_rs  = can_issue & (target == TGT_RS);
   assign issue_to_lsb = can_issue & (target == TGT_LSB);
   assign issue_rob_id = rob_tail_id;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (active & not_empty & ~can_issue & (target != TGT_ILLEGAL))
         stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: doc/issue_queue_ctrl.md
# issue_queue_ctrl

Issue controller between the Fetcher and the Decoder/dispatch path. Buffers fetched instructions in a small in-order queue and presents the head to the Decoder. Each cycle it decides whether the head can issue: the RoB must have a free entry, and so must the target structure (RS for ALU/branch/jump types, LSB for loads/stores). On issue it allocates the RoB tail id and steers the instruction. On a RoB flush it discards all buffered instructions.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- ROB_W, `ROB_SIZE_WIDTH`, RoB id width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = freeze all state
- fetch_valid  in  1  Fetcher presents an instruction
- fetch_instr  in  32  instruction word
- fetch_addr  in  32  instruction PC
- fetch_ready  out  1  queue accepts this cycle
- flush  in  1  RoB misprediction clear
- rob_full  in  1  no free RoB entry
- rob_tail_id  in  ROB_W  id the RoB will allocate next
- rs_full  in  1  RS has no free slot
- lsb_full  in  1  LSB has no free slot
- dec_instr  out  32  head instruction to Decoder
- dec_addr  out  32  head PC to Decoder
- issue_valid  out  1  head issues this cycle
- issue_to_rs  out  1  issue targets RS
- issue_to_lsb  out  1  issue targets LSB
- issue_rob_id  out  ROB_W  allocated RoB id (= rob_tail_id)
- rob_alloc  out  1  RoB allocates an entry this cycle
- stall_cycles  out  32  count of cycles with head valid but not issued

## Operation
- Storage: DEPTH entries of {instr, addr}, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Push: fetch_valid & fetch_ready & ~flush & rdy → write at tail, tail+1.
- fetch_ready = rdy & ~flush & (count < DEPTH). No dependency on rob_full, rs_full or lsb_full; the full queue does not admit a same-cycle push-while-pop.
- Classification of the head opcode [6:0]:
  - LD_TYPE, S_TYPE → LSB.
  - LUI, AUIPC, JAL, JALR, B_TYPE, I_TYPE, R_TYPE → RS.
  - Any other opcode → ILLEGAL.
- can_issue = rdy & ~flush & (count ≠ 0) & ~rob_full & (target is RS ? ~rs_full : ~lsb_full).
- issue_valid = rob_alloc = can_issue for RS/LSB classes. issue_to_rs and issue_to_lsb are one-hot, qualified by issue_valid.
- ILLEGAL head: popped when rdy & ~flush. No issue and no allocation.
- Pop on issue or on ILLEGAL drop: head+1.
- Same-cycle push and pop: count unchanged; both pointers advance.
- Flush (while rdy): head = tail = count = 0 at the edge. Any same-cycle push or issue is suppressed.
- stall_cycles: +1 each rdy cycle with count≠0, ~flush, ~can_issue, head not ILLEGAL. Wraps at 2^32. Cleared only by rst.
- rdy low: pointers, count, entries and stall_cycles hold. issue_valid, rob_alloc and fetch_ready are 0.
- dec_instr/dec_addr show the head entry whenever count≠0. When empty they are 0, so the Decoder sees a benign opcode.

## Timing
- Reset (rst high at edge): head=tail=count=0, stall_cycles=0, entries zeroed.
- Outputs after reset: fetch_ready=1 (if rdy), issue_valid=rob_alloc=issue_to_rs=issue_to_lsb=0, issue_rob_id=rob_tail_id, dec_instr=dec_addr=0, stall_cycles=0.
- rst takes priority over flush and rdy. Reset mid-operation drops all entries.
- Latency: an instruction pushed at edge N is visible at the head and may issue in cycle N+1 (1-cycle minimum fetch→issue).
- Issue outputs are combinational from the registered head and the full/flush inputs. Consumers sample them at the same edge that pops the head.
- Throughput: 1 issue/cycle sustained when DEPTH≥2 and no structure is full.

## Structure
- Shared package/config (`config.v`): opcode constants LUI, AUIPC, JAL, JALR, B_TYPE, LD_TYPE, S_TYPE, I_TYPE, R_TYPE, plus ROB_SIZE_WIDTH.
- One natural sub-module, `instr_fifo`: a generic synchronous FIFO with clear, push, pop, count and head outputs. The controller wraps it with classification, issue gating and stall counting.

## Test plan
- Reset then push 0x00500093 @0x0 (I_TYPE, addi) with nothing full → cycle after push: issue_valid=1, issue_to_rs=1, issue_rob_id=rob_tail_id, count returns to 0.
- Push 4 instructions with rob_full=1 → fetch_ready=0 after the 4th push, stall_cycles increments each cycle. Drop rob_full → one issue per cycle in PC order 0x0,0x4,0x8,0xC.
- Head sw 0x00112023 with lsb_full=1 and rs_full=0 → no issue (in-order, no bypass). lsb_full=0 → issue_to_lsb=1.
- Assert flush with 3 entries and fetch_valid=1 → no issue that cycle, no push. Next cycle count=0, dec_instr=0.
- Head opcode 0x7F → popped silently in 1 cycle: issue_valid=0, rob_alloc=0, stall_cycles unchanged.
- rdy=0 for 5 cycles mid-stream → all outputs gated, state and stall_cycles frozen. Resumes identically when rdy=1.
